// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: alucontrol codes, legality check and FSM states.
package alu_arb_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic is_legal_ctl(input logic [2:0] ctl);
    logic legal;
    case (ctl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selector: round-robin from ptr, or fixed lowest-index priority when
// ALU_ARB_FIXED_PRIO_EN is defined. Produces a one-hot grant and its index.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && !found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end
`else
  int             pos;
  logic [IDW-1:0] pos_idx;

  // Walk NREQ slots starting at ptr, wrapping at NREQ so non-power-of-2 sizes stay in range.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      pos_idx = IDW'(pos);
      if (en && !found && req[pos_idx]) begin
        found        = 1'b1;
        gnt[pos_idx] = 1'b1;
        gnt_idx      = pos_idx;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NREQ requesters, one op in flight.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_ctl,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [31:0]       resp_result,
  output logic              resp_zero,
  output logic              resp_err,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_ctl,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] gidx_q, gidx_d;
  logic [31:0]    alu_a_q, alu_a_d;
  logic [31:0]    alu_b_q, alu_b_d;
  logic [2:0]     alu_ctl_q, alu_ctl_d;
  logic [31:0]    resp_result_q, resp_result_d;
  logic           resp_zero_q, resp_zero_d;
  logic           resp_err_q, resp_err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic [IDW-1:0]  arb_ptr;
  logic            arb_en;

  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [2:0]      sel_ctl;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;
`endif

  assign arb_en = (state_q == IDLE);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (arb_ptr),
    .en      (arb_en),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // One-hot mux of the winner's operands out of the packed request buses.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_ctl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_ctl = req_ctl[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctl_d     = alu_ctl_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d         = ptr_q;
`endif
    req_ready     = '0;
    resp_valid    = '0;

    case (state_q)
      IDLE: begin
        req_ready = arb_gnt;
        if (|arb_gnt) begin
          gidx_d    = arb_idx;
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          alu_ctl_d = sel_ctl;
          state_d   = EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d     = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
`endif
        end
      end
      EXEC: begin
        // Illegal codes never expose whatever the ALU produced for them.
        if (is_legal_ctl(alu_ctl_q)) begin
          resp_result_d = alu_result;
          resp_zero_d   = alu_zero;
          resp_err_d    = 1'b0;
        end else begin
          resp_result_d = '0;
          resp_zero_d   = 1'b0;
          resp_err_d    = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid[gidx_q] = 1'b1;
        if (resp_ready[gidx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gidx_q        <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctl_q     <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctl_q     <= alu_ctl_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctl     = alu_ctl_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (op age / owner / pointer) and a behavioural ALU.
module tb_alu_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*3-1:0]  req_ctl;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [31:0]        resp_result;
  logic               resp_zero;
  logic               resp_err;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [2:0]         alu_ctl;
  logic [31:0]        alu_result;
  logic               alu_zero;
  logic               busy;

  logic [31:0] ta [NREQ];
  logic [31:0] tb [NREQ];
  logic [2:0]  tc [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Transaction-level reference state.
  bit          m_inflight;
  int          m_age;
  int          m_owner;
  int          m_ptr;
  logic [31:0] m_alu_a, m_alu_b;
  logic [2:0]  m_alu_ctl;
  logic [31:0] m_res;
  logic        m_zero, m_err;
  int          m_grants[$];
  int          m_gcyc[$];

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ctl     (req_ctl),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctl     (alu_ctl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return (a ^ b) | 32'h8000_0001;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd5);
  endfunction

  // External ALU seen by the DUT.
  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctl);
    alu_zero   = (alu_result == 32'd0);
  end

  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_ctl = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = ta[i];
      req_b[32*i +: 32] = tb[i];
      req_ctl[3*i +: 3] = tc[i];
    end
  end

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_age = 0; m_owner = 0; m_ptr = 0;
    m_alu_a = '0; m_alu_b = '0; m_alu_ctl = '0;
    m_res = '0; m_zero = 1'b0; m_err = 1'b0;
  endtask

  task automatic cyc_check();
    logic [NREQ-1:0] er, ev;
    int w;
    @(negedge clk);
    er = '0;
    ev = '0;
    if (!m_inflight) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) er[w] = 1'b1;
    end else if (m_age >= 2) begin
      ev[m_owner] = 1'b1;
    end
    check_eq("req_ready",  32'(req_ready),  32'(er));
    check_eq("resp_valid", 32'(resp_valid), 32'(ev));
    check_eq("busy",       32'(busy),       32'(m_inflight));
    check_eq("alu_a",      alu_a,           m_alu_a);
    check_eq("alu_b",      alu_b,           m_alu_b);
    check_eq("alu_ctl",    32'(alu_ctl),    32'(m_alu_ctl));
    check_eq("resp_result", resp_result,    m_res);
    check_eq("resp_zero",  32'(resp_zero),  32'(m_zero));
    check_eq("resp_err",   32'(resp_err),   32'(m_err));
  endtask

  // Advance the model with the inputs present at the coming edge, then step past it.
  task automatic cyc_adv();
    int w;
    if (!m_inflight) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) begin
        m_inflight = 1; m_age = 1; m_owner = w;
        m_alu_a = ta[w]; m_alu_b = tb[w]; m_alu_ctl = tc[w];
        m_ptr = (w + 1) % NREQ;
        m_grants.push_back(w);
        m_gcyc.push_back(cyc);
      end
    end else if (m_age == 1) begin
      m_age = 2;
      if (legal(m_alu_ctl)) begin
        m_res  = alu_fn(m_alu_a, m_alu_b, m_alu_ctl);
        m_zero = (m_res == 32'd0);
        m_err  = 1'b0;
      end else begin
        m_res = '0; m_zero = 1'b0; m_err = 1'b1;
      end
    end else if (resp_ready[m_owner]) begin
      m_inflight = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    cyc_check();
    cyc_adv();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c);
    ta[i] = a; tb[i] = b; tc[i] = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd0, 32'd0, 3'd0);
    model_reset();

    // Reset state.
    cyc_check();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single op: 5 - 3, then 7 - 7.
    set_op(0, 32'd5, 32'd3, 3'b001);
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    cycle();
    cyc_check();
    check_eq("t1_rv",   32'(resp_valid), 32'h1);
    check_eq("t1_res",  resp_result,     32'd2);
    check_eq("t1_zero", 32'(resp_zero),  32'd0);
    resp_ready = 3'b001;
    cyc_adv();
    resp_ready = '0;
    set_op(0, 32'd7, 32'd7, 3'b001);
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    cycle();
    cyc_check();
    check_eq("t1b_res",  resp_result,    32'd0);
    check_eq("t1b_zero", 32'(resp_zero), 32'd1);
    resp_ready = 3'b001;
    cyc_adv();

    // All requesters valid with responses always accepted.
    m_grants.delete();
    m_gcyc.delete();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 11 + 4), 32'(i + 1), 3'b000);
    req_valid  = 3'b111;
    resp_ready = 3'b111;
    repeat (18) cycle();
    check_eq("rr_count", 32'(m_grants.size()), 32'd6);
    for (int i = 0; i < m_grants.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check_eq("fp_order", 32'(m_grants[i]), 32'd0);
`else
      // Last grant before this was requester 0, so the rotation resumes at 1.
      check_eq("rr_order", 32'(m_grants[i]), 32'((i + 1) % NREQ));
`endif
      if (i > 0) check_eq("rr_spacing", 32'(m_gcyc[i] - m_gcyc[i-1]), 32'd3);
    end

    // Drain to IDLE, then backpressure on requester 1.
    req_valid = '0;
    repeat (3) cycle();
    resp_ready = '0;
    set_op(1, 32'h1234_0000, 32'h0000_5678, 3'b011);
    req_valid = 3'b010;
    cycle();
    req_valid = 3'b111;
    cycle();
    resp_ready = 3'b101;
    for (int k = 0; k < 5; k++) begin
      cyc_check();
      check_eq("bp_rv",  32'(resp_valid), 32'h2);
      check_eq("bp_rdy", 32'(req_ready),  32'h0);
      check_eq("bp_res", resp_result,     32'h1234_5678);
      cyc_adv();
    end
    resp_ready = 3'b010;
    cycle();
    req_valid = '0;
    cyc_check();
    check_eq("bp_idle", 32'(busy), 32'd0);
    cyc_adv();

    // Illegal code from requester 2, then a legal AND.
    resp_ready = '0;
    set_op(2, 32'hDEAD_BEEF, 32'h0000_0F0F, 3'b111);
    req_valid = 3'b100;
    cycle();
    req_valid = '0;
    cycle();
    cyc_check();
    check_eq("ill_err", 32'(resp_err), 32'd1);
    check_eq("ill_res", resp_result,   32'd0);
    resp_ready = 3'b100;
    cyc_adv();
    resp_ready = '0;
    set_op(2, 32'h0000_00F0, 32'h0000_003C, 3'b010);
    req_valid = 3'b100;
    cycle();
    req_valid = '0;
    cycle();
    cyc_check();
    check_eq("and_res", resp_result,   32'h30);
    check_eq("and_err", 32'(resp_err), 32'd0);
    resp_ready = 3'b100;
    cyc_adv();

    // Asynchronous reset while a response is pending.
    resp_ready = '0;
    set_op(1, 32'd9, 32'd4, 3'b000);
    req_valid = 3'b010;
    cycle();
    req_valid = '0;
    cycle();
    cyc_check();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_rv",   32'(resp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy),       32'd0);
    check_eq("rst_res",  resp_result,     32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    req_valid  = 3'b111;
    resp_ready = 3'b111;
    cyc_check();
    check_eq("rst_first", 32'(req_ready), 32'h1);
    cyc_adv();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_op(i, $urandom, ($urandom_range(0, 5) == 0) ? ta[i] : $urandom,
                 3'($urandom_range(0, 7)));
      end
      req_valid  = NREQ'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0) ? '1 : NREQ'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
